// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned counter, double-buffered top/compare, register port.
// Optional macro PWM_POLARITY_EN adds a per-channel output polarity register at address 3+CHANNELS.
module pwm_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
`ifdef PWM_POLARITY_EN
    parameter int AW       = $clog2(CHANNELS + 4)
`else
    parameter int AW       = $clog2(CHANNELS + 3)
`endif
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic [WIDTH-1:0]    cnt,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_end
);

    logic                en;
    logic                center;
    logic                dir_down;
    logic [WIDTH-1:0]    top_sh;
    logic [WIDTH-1:0]    top_act;
    logic [WIDTH-1:0]    cmp_sh  [CHANNELS];
    logic [WIDTH-1:0]    cmp_act [CHANNELS];
    logic [CHANNELS-1:0] pol;

    logic                wr_ctrl;
    logic                wr_top;
    logic                wr_cnt;
    logic [CHANNELS-1:0] wr_cmp;
    logic                boundary;
    logic                load_act;
    logic                dir_step;
    logic [WIDTH-1:0]    cnt_step;
    logic [CHANNELS-1:0] pwm_next;

    always_comb begin
        wr_ctrl = we && (addr == AW'(0));
        wr_top  = we && (addr == AW'(1));
        wr_cnt  = we && (addr == AW'(2));
        wr_cmp  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            wr_cmp[k] = we && (int'(addr) == 3 + k);
        end
    end

    // Next count and period boundary, always judged on the registered (pre-write) cnt.
    always_comb begin
        boundary = 1'b0;
        cnt_step = cnt;
        dir_step = dir_down;
        if (en) begin
            if (!center) begin
                if (cnt >= top_act) begin
                    boundary = 1'b1;
                    cnt_step = '0;
                end else begin
                    cnt_step = cnt + WIDTH'(1);
                end
            end else if (top_act == '0) begin
                boundary = 1'b1;
                cnt_step = '0;
                dir_step = 1'b0;
            end else if (!dir_down) begin
                if (cnt >= top_act) begin
                    dir_step = 1'b1;
                    cnt_step = top_act - WIDTH'(1);
                end else begin
                    cnt_step = cnt + WIDTH'(1);
                end
            end else if (cnt == '0) begin
                boundary = 1'b1;
                dir_step = 1'b0;
                cnt_step = WIDTH'(1);
            end else begin
                cnt_step = cnt - WIDTH'(1);
            end
        end
        load_act = !en || boundary;
    end

    always_comb begin
        pwm_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pwm_next[k] = (en && (cnt < cmp_act[k])) ^ pol[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt        <= '0;
            dir_down   <= 1'b0;
            en         <= 1'b0;
            center     <= 1'b0;
            top_sh     <= '0;
            top_act    <= '0;
            pwm_out    <= '0;
            period_end <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                cmp_sh[k]  <= '0;
                cmp_act[k] <= '0;
            end
        end else begin
            cnt        <= wr_cnt ? wdata : cnt_step;
            period_end <= boundary;
            pwm_out    <= pwm_next;
            // A mode change restarts the triangle going up; a direct load keeps the direction.
            if (wr_ctrl && (wdata[1] != center)) begin
                dir_down <= 1'b0;
            end else if (!wr_cnt) begin
                dir_down <= dir_step;
            end
            if (wr_ctrl) begin
                en     <= wdata[0];
                center <= wdata[1];
            end
            if (wr_top) top_sh <= wdata;
            if (load_act) top_act <= top_sh;
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_cmp[k]) cmp_sh[k] <= wdata;
                if (load_act) cmp_act[k] <= cmp_sh[k];
            end
        end
    end

`ifdef PWM_POLARITY_EN
    logic wr_pol;
    assign wr_pol = we && (int'(addr) == 3 + CHANNELS);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pol <= '0;
        end else if (wr_pol) begin
            pol <= wdata[CHANNELS-1:0];
        end
    end
`else
    assign pol = '0;
`endif

    always_comb begin
        rdata = '0;
        if (addr == AW'(0)) begin
            rdata[1:0] = {center, en};
        end else if (addr == AW'(1)) begin
            rdata = top_sh;
        end else if (addr == AW'(2)) begin
            rdata = cnt;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(addr) == 3 + k) rdata = cmp_sh[k];
        end
`ifdef PWM_POLARITY_EN
        if (int'(addr) == 3 + CHANNELS) rdata[CHANNELS-1:0] = pol;
`endif
    end

endmodule
